// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_pkg
// Purpose : Shared FSM encoding and counter-width helper for button_debounce.
// Revision: 1.0 - initial release
// ============================================================================
package button_pkg;

   localparam logic [1:0] c_ST_IDLE         = 2'd0;
   localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] c_ST_HELD         = 2'd2;
   localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

   typedef enum logic [1:0] {
      IDLE         = c_ST_IDLE,
      PRESS_WAIT   = c_ST_PRESS_WAIT,
      HELD         = c_ST_HELD,
      RELEASE_WAIT = c_ST_RELEASE_WAIT
   } btn_state_t;

   // Bits needed to hold values 0..max_count inclusive.
   function automatic int cnt_width(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module  : button_debounce_channel
// Purpose : One button: 2-flop synchroniser, stability counter, press FSM and
//           optional auto-repeat (enabled by BUTTON_REPEAT_EN).
// Revision: 1.0 - initial release
// ============================================================================
module button_debounce_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_n_async,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int              c_CW     = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [c_CW-1:0] c_DB_MAX = c_CW'(DEBOUNCE_CYCLES);
   localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

   logic            r_sync1;
   logic            r_sync2;
   logic            w_sync_pressed;
   btn_state_t      r_state;
   btn_state_t      w_state_nxt;
   logic [c_CW-1:0] r_cnt;
   logic [c_CW-1:0] w_cnt_nxt;
   logic            w_accept_press;
   logic            w_accept_release;
   logic            w_level_nxt;
   logic            w_repeat;
   logic            r_level;
   logic            r_press;
   logic            r_release;

   assign w_sync_pressed = ~r_sync2;

   // Counter leaves each state at 0; the count only advances in the WAIT states.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = '0;
      w_accept_press   = 1'b0;
      w_accept_release = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_sync_pressed) begin
               w_state_nxt = PRESS_WAIT;
               w_cnt_nxt   = c_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!w_sync_pressed) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == c_DB_MAX) begin
               w_state_nxt    = HELD;
               w_accept_press = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_ONE;
            end
         end
         HELD: begin
            if (!w_sync_pressed) begin
               w_state_nxt = RELEASE_WAIT;
               w_cnt_nxt   = c_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (w_sync_pressed) begin
               w_state_nxt = HELD;
            end else if (r_cnt == c_DB_MAX) begin
               w_state_nxt      = IDLE;
               w_accept_release = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);

`ifdef BUTTON_REPEAT_EN
   localparam int c_RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int c_RW   = cnt_width(c_RMAX);
   localparam logic [c_RW-1:0] c_REP_DELAY  = c_RW'(REPEAT_DELAY);
   localparam logic [c_RW-1:0] c_REP_PERIOD = c_RW'(REPEAT_PERIOD);
   localparam logic [c_RW-1:0] c_REP_ONE    = c_RW'(1);

   logic [c_RW-1:0] r_rep_cnt;
   logic [c_RW-1:0] w_rep_inc;
   logic            r_rep_first;
   logic            w_in_hold;
   logic            w_rep_hit;

   assign w_in_hold = (r_state == HELD) || (r_state == RELEASE_WAIT);
   assign w_rep_inc = r_rep_cnt + c_REP_ONE;
   // A repeat due on the release edge is dropped so the two strobes never overlap.
   assign w_rep_hit = w_in_hold && !w_accept_release &&
                      (w_rep_inc == (r_rep_first ? c_REP_DELAY : c_REP_PERIOD));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b1;
      end else if (!w_in_hold || w_accept_release) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b1;
      end else if (w_rep_hit) begin
         r_rep_cnt   <= '0;
         r_rep_first <= 1'b0;
      end else begin
         r_rep_cnt   <= w_rep_inc;
      end
   end

   assign w_repeat = w_rep_hit;
`else
   assign w_repeat = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_sync1   <= btn_n_async;
         r_sync2   <= r_sync1;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_level   <= w_level_nxt;
         r_press   <= w_accept_press | w_repeat;
         r_release <= w_accept_release;
      end
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;

endmodule
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module  : button_debounce
// Purpose : NUM_BUTTONS independent debounce channels for active-low pins;
//           auto-repeat on held buttons when BUTTON_REPEAT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module button_debounce
   import button_pkg::*;
#(
   parameter int NUM_BUTTONS     = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 2500000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_BUTTONS-1:0] btn_n_async,
   output logic [NUM_BUTTONS-1:0] btn_level,
   output logic [NUM_BUTTONS-1:0] btn_press,
   output logic [NUM_BUTTONS-1:0] btn_release
);

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
      button_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk         (clk),
         .reset_n     (reset_n),
         .btn_n_async (btn_n_async[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// Testbench for button_debounce: directed scenarios plus random pin activity,
// all compared against a run-length / hold-age reference model.
module tb_button_debounce;

   localparam int NB = 2;
   localparam int DB = 8;
   localparam int RD = 20;
   localparam int RP = 5;
`ifdef BUTTON_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic          clk         = 1'b0;
   logic          reset_n     = 1'b0;
   logic [NB-1:0] btn_n_async = '1;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   always #5 clk = ~clk;

   button_debounce #(
      .NUM_BUTTONS     (NB),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_n_async (btn_n_async),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   // Reference model: the level flips after DB+1 consecutive synchronised samples
   // that disagree with it; repeats fire at hold ages RD, RD+RP, ...
   logic [NB-1:0] m_s1 = '1, m_s2 = '1;
   logic [NB-1:0] m_level = '0, m_press = '0, m_release = '0;
   int            m_run[NB];
   int            m_age[NB];
   logic          sp, was;

   always @(posedge clk) begin
      edge_n++;
      if (!reset_n) begin
         m_s1 = '1; m_s2 = '1;
         m_level = '0; m_press = '0; m_release = '0;
         for (int c = 0; c < NB; c++) begin
            m_run[c] = 0; m_age[c] = 0;
         end
      end else begin
         for (int c = 0; c < NB; c++) begin
            sp  = ~m_s2[c];
            was = m_level[c];
            m_press[c] = 1'b0; m_release[c] = 1'b0;
            if (sp != was) begin
               m_run[c]++;
               if (m_run[c] == DB + 1) begin
                  m_level[c] = sp; m_run[c] = 0;
                  m_press[c] = sp; m_release[c] = ~sp;
               end
            end else begin
               m_run[c] = 0;
            end
            if (was) begin
               if (m_release[c]) m_age[c] = 0;
               else begin
                  m_age[c]++;
                  if (REP_EN && m_age[c] >= RD && (m_age[c] - RD) % RP == 0) m_press[c] = 1'b1;
               end
            end else begin
               m_age[c] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = btn_n_async;
      end
   end

   task automatic cycle(input logic [NB-1:0] pins);
      btn_n_async = pins;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(2'b00);
         checks++;
         if ({btn_level, btn_press, btn_release} !== 6'b0) begin
            failures++;
            $display("FAIL reset_hold: got lvl/prs/rel %b/%b/%b want 00/00/00", btn_level, btn_press, btn_release);
         end
      end
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle(2'b11);
         checks++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
            failures++;
            $display("FAIL reset_idle t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                     btn_level, btn_press, btn_release, m_level, m_press, m_release);
         end
      end
   endtask

   task automatic test_clean_press_release();
      int e0, ep, np, er, nr;
      e0 = edge_n + 1; ep = -1; np = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(2'b10);
         checks++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
            failures++;
            $display("FAIL clean_press t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                     btn_level, btn_press, btn_release, m_level, m_press, m_release);
         end
         if (btn_press[0]) begin np++; if (ep < 0) ep = edge_n; end
      end
      checks++;
      if (ep - e0 !== DB + 2 || np !== 1) begin
         failures++;
         $display("FAIL press_latency: got latency %0d count %0d want %0d count 1", ep - e0, np, DB + 2);
      end
      // Release lands exactly on the first repeat slot, which must be suppressed.
      e0 = edge_n + 1; er = -1; nr = 0; np = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(2'b11);
         checks++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
            failures++;
            $display("FAIL clean_release t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                     btn_level, btn_press, btn_release, m_level, m_press, m_release);
         end
         if (btn_release[0]) begin nr++; if (er < 0) er = edge_n; end
         if (btn_press[0]) np++;
      end
      checks++;
      if (er - e0 !== DB + 2 || nr !== 1 || np !== 0 || btn_level !== 2'b00) begin
         failures++;
         $display("FAIL release_latency: got latency %0d rel %0d prs %0d lvl %b want %0d 1 0 00",
                  er - e0, nr, np, btn_level, DB + 2);
      end
   endtask

   task automatic test_bounce();
      int es, ep, np, nb;
      nb = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(((i / 3) % 2 == 0) ? 2'b10 : 2'b11);
         if (btn_press !== 2'b00 || btn_release !== 2'b00 || btn_level !== 2'b00) nb++;
      end
      checks++;
      if (nb !== 0) begin
         failures++;
         $display("FAIL bounce_quiet: got %0d active cycles want 0", nb);
      end
      es = edge_n + 1; ep = -1; np = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(2'b10);
         checks++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
            failures++;
            $display("FAIL bounce_settle t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                     btn_level, btn_press, btn_release, m_level, m_press, m_release);
         end
         if (btn_press[0]) begin np++; if (ep < 0) ep = edge_n; end
      end
      checks++;
      if (ep - es !== DB + 2 || np !== 1) begin
         failures++;
         $display("FAIL bounce_press: got latency %0d count %0d want %0d count 1", ep - es, np, DB + 2);
      end
      // Random short excursions while held: each shorter than DB, so none may register.
      nb = 0;
      for (int k = 0; k < 8; k++) begin
         int len;
         len = $urandom_range(1, DB - 1);
         for (int i = 0; i < len; i++) begin
            cycle((k % 2 == 0) ? 2'b11 : 2'b10);
            if (btn_release !== 2'b00 || btn_level[0] !== 1'b1) nb++;
         end
      end
      checks++;
      if (nb !== 0) begin
         failures++;
         $display("FAIL glitch_held: got %0d disturbed cycles want 0", nb);
      end
      for (int i = 0; i < 14; i++) cycle(2'b11);
   endtask

   task automatic test_simultaneous();
      int nboth, nbad;
      nboth = 0; nbad = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(2'b00);
         checks++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
            failures++;
            $display("FAIL simul_press t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                     btn_level, btn_press, btn_release, m_level, m_press, m_release);
         end
         if (btn_press === 2'b11) nboth++;
      end
      checks++;
      if (nboth !== 1) begin
         failures++;
         $display("FAIL simul_strobe: got %0d cycles with press=11 want 1", nboth);
      end
      for (int i = 0; i < 13; i++) begin
         cycle((i < 5) ? 2'b10 : 2'b00);
         if (btn_level !== 2'b11 || btn_press !== 2'b00 || btn_release !== 2'b00) nbad++;
      end
      checks++;
      if (nbad !== 0) begin
         failures++;
         $display("FAIL simul_glitch: got %0d disturbed cycles want 0", nbad);
      end
      for (int i = 0; i < 20; i++) begin
         cycle(2'b11);
         checks++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
            failures++;
            $display("FAIL simul_release t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                     btn_level, btn_press, btn_release, m_level, m_press, m_release);
         end
      end
   endtask

   task automatic test_reset_mid_press();
      int er, ep;
      for (int i = 0; i < 7; i++) cycle(2'b10);
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(2'b10);
         checks++;
         if ({btn_level, btn_press, btn_release} !== 6'b0) begin
            failures++;
            $display("FAIL reset_mid: got %b/%b/%b want 00/00/00", btn_level, btn_press, btn_release);
         end
      end
      reset_n = 1'b1;
      er = edge_n + 1; ep = -1;
      for (int i = 0; i < 15; i++) begin
         cycle(2'b10);
         if (btn_press[0] && ep < 0) ep = edge_n;
      end
      checks++;
      if (ep - er !== DB + 2) begin
         failures++;
         $display("FAIL reset_repress: got latency %0d want %0d", ep - er, DB + 2);
      end
      for (int i = 0; i < 20; i++) cycle(2'b11);
   endtask

   task automatic test_hold_repeat();
      int tp, nrep, nafter;
      bit released;
      tp = -1; nrep = 0; nafter = 0; released = 0;
      for (int i = 0; i < 15 && tp < 0; i++) begin
         cycle(2'b10);
         if (btn_press[0]) tp = edge_n;
      end
      for (int i = 0; i < 60; i++) begin
         cycle(2'b10);
         checks++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
            failures++;
            $display("FAIL hold t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                     btn_level, btn_press, btn_release, m_level, m_press, m_release);
         end
         if (btn_press[0]) nrep++;
      end
      checks++;
      if (tp < 0 || nrep !== (REP_EN ? (60 - RD) / RP + 1 : 0)) begin
         failures++;
         $display("FAIL repeat_count: got %0d (press seen %0d) want %0d", nrep, tp >= 0,
                  REP_EN ? (60 - RD) / RP + 1 : 0);
      end
      for (int i = 0; i < 25; i++) begin
         cycle(2'b11);
         if (released && btn_press[0]) nafter++;
         if (btn_release[0]) released = 1;
      end
      checks++;
      if (!released || nafter !== 0) begin
         failures++;
         $display("FAIL repeat_after_release: got released=%0d presses=%0d want 1 0", released, nafter);
      end
   endtask

   task automatic test_random();
      int       left[NB];
      logic [NB-1:0] pins;
      pins = '1;
      for (int c = 0; c < NB; c++) left[c] = 0;
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < NB; c++) begin
            if (left[c] == 0) begin
               pins[c] = ~pins[c];
               left[c] = $urandom_range(1, 2 * DB);
            end
            left[c]--;
         end
         cycle(pins);
         checks++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release} ||
             (btn_press & btn_release) !== 2'b00) begin
            failures++;
            $display("FAIL random t=%0t: got %b/%b/%b want %b/%b/%b", $time,
                     btn_level, btn_press, btn_release, m_level, m_press, m_release);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press_release();
      test_bounce();
      test_simultaneous();
      test_reset_mid_press();
      test_hold_repeat();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
